// File: rtl/decoder_nx_seq_if.sv
// Bus bundle for decoder_nx_seq: code input handshake, scan controls and decoded outputs.
// In is transferred on a rising edge where In_valid & In_ready; In_ready never depends on In_valid.
interface decoder_nx_seq_if #(
  parameter int N       = 2,
  parameter int DWELL_W = 4
);
  logic                 En;
  logic                 Mode;
  logic [N-1:0]         In;
  logic                 In_valid;
  logic                 In_ready;
  logic [DWELL_W-1:0]   Dwell;
  logic [(1<<N)-1:0]    Out;
  logic                 Out_valid;
  logic [N-1:0]         Idx;

  modport master (
    output En, Mode, In, In_valid, Dwell,
    input  In_ready, Out, Out_valid, Idx
  );

  modport slave (
    input  En, Mode, In, In_valid, Dwell,
    output In_ready, Out, Out_valid, Idx
  );
endinterface

// File: rtl/decoder_nx_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready input, clock enable and
// a self-running scan mode that walks a one-hot strobe with programmable dwell.
module decoder_nx_seq #(
  parameter int N       = 2,
  parameter int DWELL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  decoder_nx_seq_if.slave   bus,
  output logic [1:0]        state_dbg
);
  localparam int OW = 1 << N;
  localparam logic [OW-1:0]      OUT_ONE = OW'(1);
  localparam logic [N-1:0]       IDX_ONE = N'(1);
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIRECT = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [OW-1:0]      out_q, out_d;
  logic [N-1:0]       idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               valid_q, valid_d;

  logic               in_ready;
  logic               accept;
  logic [N-1:0]       idx_inc;

  assign in_ready = bus.En & ~bus.Mode & ~rst;
  assign accept   = bus.In_valid & in_ready;
  assign idx_inc  = idx_q + IDX_ONE;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (bus.En) begin
      case (state_q)
        S_IDLE, S_DIRECT: begin
          if (bus.Mode) begin
            state_d = S_SCAN;
            out_d   = OUT_ONE;
            idx_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b1;
          end else if (accept) begin
            state_d = S_DIRECT;
            out_d   = OUT_ONE << bus.In;
            idx_d   = bus.In;
            valid_d = 1'b1;
          end
        end
        S_SCAN: begin
          // Leaving scan keeps the last strobe unless a code lands on the same edge.
          if (!bus.Mode) begin
            state_d = S_DIRECT;
            if (accept) begin
              out_d   = OUT_ONE << bus.In;
              idx_d   = bus.In;
              valid_d = 1'b1;
            end
          end else if (cnt_q >= bus.Dwell) begin
            idx_d = idx_inc;
            out_d = OUT_ONE << idx_inc;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out       = out_q;
  assign bus.Out_valid = valid_q;
  assign bus.Idx       = idx_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_decoder_nx_seq.sv
// Bench for decoder_nx_seq: an N=2 instance for direct decode and gating, an
// N=3 instance for scan, dwell, mode switching and mid-scan reset.
module tb_decoder_nx_seq;
  logic clk = 1'b0;
  logic rst2 = 1'b1;
  logic rst3 = 1'b1;
  logic [1:0] state2, state3;

  always #5 clk = ~clk;

  decoder_nx_seq_if #(.N(2), .DWELL_W(4)) if2 ();
  decoder_nx_seq_if #(.N(3), .DWELL_W(4)) if3 ();

  decoder_nx_seq #(.N(2), .DWELL_W(4)) u_dut2 (
    .clk(clk), .rst(rst2), .bus(if2), .state_dbg(state2)
  );
  decoder_nx_seq #(.N(3), .DWELL_W(4)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(if3), .state_dbg(state3)
  );

  // Entry: {sel, in_ready, out_valid, out[7:0], idx[2:0]}
  logic [13:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit busy = 1'b0;

  function automatic logic [12:0] mk(input bit rdy, input bit vld,
                                     input logic [7:0] o, input logic [2:0] ix);
    return {rdy, vld, o, ix};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Drives one cycle of inputs right after a rising edge and queues what the
  // next edge must produce.
  task automatic cyc(input bit sel, input bit r, input bit en, input bit mode,
                     input logic [2:0] in, input bit inv, input logic [3:0] dw,
                     input logic [12:0] ex);
    @(posedge clk);
    #1;
    if (sel) begin
      rst3 = r; if3.En = en; if3.Mode = mode; if3.In = in;
      if3.In_valid = inv; if3.Dwell = dw;
    end else begin
      rst2 = r; if2.En = en; if2.Mode = mode; if2.In = in[1:0];
      if2.In_valid = inv; if2.Dwell = dw;
    end
    exp_q.push_back({sel, ex});
  endtask

  // Monitor: in_ready checked mid-cycle, registered outputs after the edge.
  initial begin : monitor
    logic [13:0] e;
    logic [7:0]  act_out;
    logic [2:0]  act_idx;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        busy = 1'b1;
        e = exp_q.pop_front();
        check("in_ready", {7'd0, e[13] ? if3.In_ready : if2.In_ready}, {7'd0, e[12]});
        @(posedge clk);
        #1;
        act_out = e[13] ? if3.Out : {4'd0, if2.Out};
        act_idx = e[13] ? if3.Idx : {1'b0, if2.Idx};
        check("out_valid", {7'd0, e[13] ? if3.Out_valid : if2.Out_valid}, {7'd0, e[11]});
        check("out", act_out, e[10:3]);
        check("idx", {5'd0, act_idx}, {5'd0, e[2:0]});
        busy = 1'b0;
      end
    end
  end

  initial begin : stim
    int k;
    if2.En = 0; if2.Mode = 0; if2.In = 0; if2.In_valid = 0; if2.Dwell = 0;
    if3.En = 0; if3.Mode = 0; if3.In = 0; if3.In_valid = 0; if3.Dwell = 0;

    // N=2: reset, then back-to-back accepts of 0..3
    cyc(0, 1, 1, 0, 3'd0, 1, 4'd0, mk(0, 0, 8'h00, 3'd0));
    cyc(0, 1, 1, 0, 3'd1, 1, 4'd0, mk(0, 0, 8'h00, 3'd0));
    cyc(0, 0, 1, 0, 3'd0, 1, 4'd0, mk(1, 1, 8'h01, 3'd0));
    cyc(0, 0, 1, 0, 3'd1, 1, 4'd0, mk(1, 1, 8'h02, 3'd1));
    cyc(0, 0, 1, 0, 3'd2, 1, 4'd0, mk(1, 1, 8'h04, 3'd2));
    cyc(0, 0, 1, 0, 3'd3, 1, 4'd0, mk(1, 1, 8'h08, 3'd3));
    // N=2: En low gates the handshake and holds Out
    cyc(0, 0, 0, 0, 3'd2, 1, 4'd0, mk(0, 1, 8'h08, 3'd3));
    cyc(0, 0, 0, 0, 3'd2, 1, 4'd0, mk(0, 1, 8'h08, 3'd3));
    cyc(0, 0, 0, 0, 3'd2, 1, 4'd0, mk(0, 1, 8'h08, 3'd3));
    cyc(0, 0, 1, 0, 3'd2, 1, 4'd0, mk(1, 1, 8'h04, 3'd2));

    // N=3: reset, then scan entry with Dwell=2
    cyc(1, 1, 1, 1, 3'd0, 0, 4'd2, mk(0, 0, 8'h00, 3'd0));
    cyc(1, 0, 1, 1, 3'd0, 0, 4'd2, mk(0, 1, 8'h01, 3'd0));
    // Full 24-cycle sweep ending in a wrap to index 0; In_valid is ignored
    for (int c = 1; c <= 24; c++) begin
      k = (c / 3) % 8;
      cyc(1, 0, 1, 1, 3'd5, 1, 4'd2, mk(0, 1, 8'd1 << k, 3'(k)));
    end
    // Dwell=0 advances every cycle
    for (int j = 1; j <= 4; j++)
      cyc(1, 0, 1, 1, 3'd0, 0, 4'd0, mk(0, 1, 8'd1 << j, 3'(j)));
    // Dwell=7: count up to 5 while holding index 4, then Dwell=1 forces advance
    for (int j = 0; j < 5; j++)
      cyc(1, 0, 1, 1, 3'd0, 0, 4'd7, mk(0, 1, 8'h10, 3'd4));
    cyc(1, 0, 1, 1, 3'd0, 0, 4'd1, mk(0, 1, 8'h20, 3'd5));
    // Leave scan without accept: last strobe held
    cyc(1, 0, 1, 0, 3'd0, 0, 4'd1, mk(1, 1, 8'h20, 3'd5));
    // Re-enter scan, walk to index 5, leave with same-edge accept of 2
    cyc(1, 0, 1, 1, 3'd0, 0, 4'd0, mk(0, 1, 8'h01, 3'd0));
    for (int j = 1; j <= 5; j++)
      cyc(1, 0, 1, 1, 3'd0, 0, 4'd0, mk(0, 1, 8'd1 << j, 3'(j)));
    cyc(1, 0, 1, 0, 3'd2, 1, 4'd0, mk(1, 1, 8'h04, 3'd2));
    cyc(1, 0, 1, 0, 3'd6, 0, 4'd0, mk(1, 1, 8'h04, 3'd2));
    // Scan to index 5, freeze with En=0 while Mode drops, resume to index 6
    cyc(1, 0, 1, 1, 3'd0, 0, 4'd0, mk(0, 1, 8'h01, 3'd0));
    for (int j = 1; j <= 5; j++)
      cyc(1, 0, 1, 1, 3'd0, 0, 4'd0, mk(0, 1, 8'd1 << j, 3'(j)));
    cyc(1, 0, 0, 0, 3'd0, 1, 4'd0, mk(0, 1, 8'h20, 3'd5));
    cyc(1, 0, 0, 0, 3'd0, 1, 4'd0, mk(0, 1, 8'h20, 3'd5));
    cyc(1, 0, 1, 1, 3'd0, 0, 4'd0, mk(0, 1, 8'h40, 3'd6));
    // Reset mid-scan, then IDLE holds zeros until an accept
    cyc(1, 1, 1, 1, 3'd3, 1, 4'd0, mk(0, 0, 8'h00, 3'd0));
    cyc(1, 0, 1, 0, 3'd0, 0, 4'd0, mk(1, 0, 8'h00, 3'd0));
    cyc(1, 0, 1, 0, 3'd7, 1, 4'd0, mk(1, 1, 8'h80, 3'd7));
    cyc(1, 0, 0, 0, 3'd0, 0, 4'd0, mk(0, 1, 8'h80, 3'd7));

    for (int i = 0; i < 20 && (exp_q.size() > 0 || busy); i++)
      @(posedge clk);
    #2;
    if (exp_q.size() > 0 || busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decoder_nx_seq.md
# decoder_nx_seq

Parametrised, registered N-to-2^N one-hot decoder. It is the successor to the team's fixed 2-to-4 combinational decoder. It adds a valid/ready input handshake, a clock enable, and a self-running scan mode that walks a one-hot strobe across all outputs with a programmable dwell time. It drives one-hot select and strobe buses: bank selects, LED/segment multiplexing, and round-robin enables.

## Interface
Parameters:
- N, default 2: input code width; output width is 2^N.
- DWELL_W, default 4: width of the Dwell input.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- En  in  1  clock enable; when low, all state holds.
- Mode  in  1  0 = direct decode, 1 = scan.
- In  in  N  code to decode in direct mode.
- In_valid  in  1  In carries a code.
- In_ready  out  1  block can accept In this cycle (combinational).
- Dwell  in  DWELL_W  each scan index is held for Dwell+1 cycles.
- Out  out  2^N  registered one-hot output; all zeros only before the first update after reset.
- Out_valid  out  1  Out holds a decoded or scanned value.
- Idx  out  N  binary index of the currently asserted Out bit.

## Operation
- State machine states: IDLE, DIRECT, SCAN.
- Reset (rst=1 at a clock edge):
  - state = IDLE, Out = 0, Out_valid = 0, Idx = 0, dwell counter cnt = 0.
  - rst dominates all other inputs, including mid-scan and mid-handshake.
- In_ready = En & ~Mode & ~rst.
- A transfer (accept) occurs in a cycle where In_valid & In_ready.
- IDLE:
  - accept -> DIRECT.
  - En & Mode -> SCAN.
  - Otherwise stay in IDLE with outputs at their reset values.
- DIRECT:
  - On accept: Out <= 1 << In, Idx <= In, Out_valid <= 1.
  - Without accept, Out and Idx hold.
  - En & Mode -> SCAN.
- SCAN:
  - In_ready = 0; In and In_valid are ignored.
  - On entry (first SCAN cycle edge): Out <= 1 (Idx 0), cnt <= 0, Out_valid <= 1.
  - Each enabled cycle thereafter:
    - If cnt >= Dwell: Idx <= Idx+1 modulo 2^N (wrap from 2^N-1 to 0), Out <= 1 << (Idx+1), cnt <= 0.
    - Else: cnt <= cnt+1.
  - Dwell is sampled live every cycle. Lowering Dwell below the current cnt forces an advance on the next enabled edge.
  - Dwell = 0 advances every cycle.
  - En & ~Mode -> DIRECT. Out and Idx keep the last scan value until an accept. An accept in the same cycle as the mode change is legal and updates Out at that edge.
- En = 0:
  - State, Out, Idx, cnt and Out_valid all hold.
  - In_ready = 0.
  - Mode changes are not acted on until En returns to 1.
- Out is always exactly one-hot (popcount 1) whenever Out_valid = 1.
- Idx is always consistent with Out: Out == 1 << Idx.
- Arithmetic:
  - cnt is DWELL_W bits wide; the comparison is unsigned.
  - The Idx increment is N bits wide and wraps naturally.

## Timing
- Direct latency: 1 cycle. A code accepted at edge k appears on Out/Idx immediately after edge k. Full throughput: one code per cycle.
- Scan entry: 1 cycle after the En & Mode edge, Out = 0…01.
- Scan period: Dwell+1 cycles per index; full sweep = 2^N·(Dwell+1) cycles.
- Out, Out_valid and Idx are glitch-free register outputs. In_ready is combinational from En, Mode and rst only; it never depends on In_valid.
- Back-to-back accepts with different codes produce back-to-back one-hot outputs with no all-zero gap.

## Test plan
- Reset and direct decode, N=2:
  - Stimulus: assert rst for 2 cycles, then accept In = 00, 01, 10, 11 on consecutive cycles.
  - Required: Out = 0000 and Out_valid = 0 during reset. Then Out = 0001, 0010, 0100, 1000 and Idx = 0..3, each one cycle after its accept.
- Handshake gating:
  - Stimulus: N=2. Hold In_valid = 1, In = 10, with En = 0 for 3 cycles, then En = 1.
  - Required: In_ready = 0 and Out held at its prior value while En = 0. Out = 0100 one cycle after En rises.
- Scan with dwell, N=3:
  - Stimulus: Mode = 1, Dwell = 2, En = 1.
  - Required: Out = 0x01 for 3 cycles, then 0x02, …, 0x80, then wraps to 0x01. Full sweep = 24 cycles. In_ready = 0 throughout.
- Dwell edge cases:
  - Dwell = 0: Out changes every cycle.
  - Change Dwell from 7 to 1 while cnt = 5: advance on the next edge.
- Mode switch:
  - Stimulus: mid-scan at Idx = 5 (N=3), drop Mode and accept In = 2 in the same cycle.
  - Required: Out = 0x04 and Idx = 2 after that edge.
  - Also check: switching without an accept keeps Out = 0x20.
- Reset mid-operation:
  - Stimulus: assert rst during a scan with Idx = 6.
  - Required: next edge gives Out = 0, Out_valid = 0, Idx = 0. The block returns to IDLE.
